// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer (master) and the RV32I datapath (slave).
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic       branch_cond;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       target_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       instr_retired;
    logic       trap;
    logic [2:0] state;

    modport master (
        input  opcode, branch_cond, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src, target_write,
               alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
               instr_retired, trap, state
    );

    modport slave (
        output opcode, branch_cond, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src, target_write,
               alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
               instr_retired, trap, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core with illegal-opcode and memory-timeout traps.
// Optional cycle/retire counters are enabled by defining MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    multicycle_ctrl_if.master   bus
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0]         cycle_cnt,
    output logic [31:0]         retire_cnt
`endif
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [2:0] C_NONE = 3'd0;
    localparam logic [2:0] C_R    = 3'd1;
    localparam logic [2:0] C_I    = 3'd2;
    localparam logic [2:0] C_LD   = 3'd3;
    localparam logic [2:0] C_ST   = 3'd4;
    localparam logic [2:0] C_BR   = 3'd5;

    // A zero timeout would give a zero-width counter; keep one bit that is never compared.
    localparam int             CW        = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  WAIT_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam bit             TO_EN     = (MEM_TIMEOUT != 0);

    logic [2:0]    state_q, state_d;
    logic [2:0]    cls_q, cls_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          timeout_hit;

    function automatic logic [2:0] decode_class(input logic [6:0] op);
        case (op)
            7'b0110011: decode_class = C_R;
            7'b0010011: decode_class = C_I;
            7'b0000011: decode_class = C_LD;
            7'b0100011: decode_class = C_ST;
            7'b1100011: decode_class = C_BR;
            default:    decode_class = C_NONE;
        endcase
    endfunction

    assign timeout_hit = TO_EN && (wait_q == WAIT_LAST);

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        wait_d  = wait_q;
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ready)  state_d = S_DECODE;
                else if (timeout_hit) state_d = S_TRAP;
                else                wait_d = wait_q + CW'(1);
            end
            S_DECODE: begin
                cls_d   = decode_class(bus.opcode);
                state_d = (cls_d == C_NONE) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                case (cls_q)
                    C_R, C_I:   state_d = S_WB;
                    C_LD, C_ST: state_d = S_MEM;
                    C_BR:       state_d = S_FETCH;
                    default:    state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                if (bus.mem_ready)    state_d = (cls_q == C_LD) ? S_WB : S_FETCH;
                else if (timeout_hit) state_d = S_TRAP;
                else                  wait_d = wait_q + CW'(1);
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = S_TRAP;
        endcase
        // Every fresh memory request starts its own timeout window.
        if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM)))
            wait_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            cls_q   <= C_NONE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        bus.mem_req       = 1'b0;
        bus.mem_we        = 1'b0;
        bus.iord          = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_src        = 1'b0;
        bus.target_write  = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.reg_write     = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.instr_retired = 1'b0;
        bus.trap          = 1'b0;
        // Gated by rst so nothing, including mem_req, escapes while reset is held.
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    bus.mem_req   = 1'b1;
                    bus.alu_src_b = 2'b10;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                    end
                end
                S_DECODE: begin
                    bus.alu_src_b    = 2'b01;
                    bus.target_write = 1'b1;
                end
                S_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    case (cls_q)
                        C_R: bus.alu_op = 2'b10;
                        C_I: begin
                            bus.alu_src_b = 2'b01;
                            bus.alu_op    = 2'b10;
                        end
                        C_LD, C_ST: bus.alu_src_b = 2'b01;
                        C_BR: begin
                            bus.alu_op        = 2'b01;
                            bus.instr_retired = 1'b1;
                            if (bus.branch_cond) begin
                                bus.pc_write = 1'b1;
                                bus.pc_src   = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    bus.mem_req       = 1'b1;
                    bus.iord          = 1'b1;
                    bus.mem_we        = (cls_q == C_ST);
                    bus.instr_retired = bus.mem_ready && (cls_q == C_ST);
                end
                S_WB: begin
                    bus.reg_write     = 1'b1;
                    bus.mem_to_reg    = (cls_q == C_LD);
                    bus.instr_retired = 1'b1;
                end
                S_TRAP:  bus.trap = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.state = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt_q, retire_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            if (state_q != S_TRAP)  cycle_cnt_q  <= cycle_cnt_q + 32'd1;
            if (bus.instr_retired)  retire_cnt_q <= retire_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt  = cycle_cnt_q;
    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed plus randomized bench for multicycle_ctrl; expected per-cycle traces are built from instruction-level rules.
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;
    localparam int         TMO    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus();

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt, retire_cnt;
    multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .bus(bus), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt));
`else
    multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    // Expected outputs per cycle: state, the mem_ready/branch_cond to drive, and the output bundle.
    typedef struct packed {
        logic [2:0]  st;
        logic        rdy;
        logic        bc;
        logic [15:0] o;
    } cyc_t;

    cyc_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_cyc = 0;
    int   exp_ret = 0;

    logic [15:0] obs_o;
    assign obs_o = {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write, bus.pc_src,
                    bus.target_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                    bus.reg_write, bus.mem_to_reg, bus.instr_retired, bus.trap};

    function automatic logic [15:0] mk(input logic req, input logic we, input logic iord,
                                       input logic irw, input logic pcw, input logic pcs,
                                       input logic tw, input logic asa, input logic [1:0] asb,
                                       input logic [1:0] aop, input logic rw, input logic m2r,
                                       input logic ret, input logic trp);
        mk = {req, we, iord, irw, pcw, pcs, tw, asa, asb, aop, rw, m2r, ret, trp};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic trap_tail(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c.st = 3'd5; c.rdy = i[0]; c.bc = 1'($urandom);
            c.o  = mk(0,0,0,0,0,0,0,0,2'b00,2'b00,0,0,0,1);
            q.push_back(c);
        end
    endtask

    // fw/mw = number of wait cycles before mem_ready; TMO or more means memory never answers.
    task automatic build(input logic [6:0] op, input int fw, input int mw, input logic bc);
        cyc_t c;
        bit   is_ld, is_st, is_br, is_r, is_i;
        is_r  = (op == OP_R);  is_i = (op == OP_I);  is_ld = (op == OP_LD);
        is_st = (op == OP_ST); is_br = (op == OP_BR);
        for (int i = 0; i < TMO && i <= fw; i++) begin
            c.st = 3'd0; c.bc = bc; c.rdy = (i == fw);
            c.o  = mk(1,0,0,c.rdy,c.rdy,0,0,0,2'b10,2'b00,0,0,0,0);
            q.push_back(c);
        end
        if (fw >= TMO) begin trap_tail(3); return; end
        c.st = 3'd1; c.bc = bc; c.rdy = 1'($urandom);
        c.o  = mk(0,0,0,0,0,0,1,0,2'b01,2'b00,0,0,0,0);
        q.push_back(c);
        if (!(is_r || is_i || is_ld || is_st || is_br)) begin trap_tail(20); return; end
        c.st = 3'd2; c.bc = bc; c.rdy = 1'($urandom);
        if (is_r)       c.o = mk(0,0,0,0,0,0,0,1,2'b00,2'b10,0,0,0,0);
        else if (is_i)  c.o = mk(0,0,0,0,0,0,0,1,2'b01,2'b10,0,0,0,0);
        else if (is_br) c.o = mk(0,0,0,0,bc,bc,0,1,2'b00,2'b01,0,0,1,0);
        else            c.o = mk(0,0,0,0,0,0,0,1,2'b01,2'b00,0,0,0,0);
        q.push_back(c);
        if (is_ld || is_st) begin
            for (int i = 0; i < TMO && i <= mw; i++) begin
                c.st = 3'd3; c.bc = bc; c.rdy = (i == mw);
                c.o  = mk(1,is_st,1,0,0,0,0,0,2'b00,2'b00,0,0,is_st && c.rdy,0);
                q.push_back(c);
            end
            if (mw >= TMO) begin trap_tail(3); return; end
        end
        if (is_r || is_i || is_ld) begin
            c.st = 3'd4; c.bc = bc; c.rdy = 1'($urandom);
            c.o  = mk(0,0,0,0,0,0,0,0,2'b00,2'b00,1,is_ld,1,0);
            q.push_back(c);
        end
    endtask

    // Drives one cycle per queue entry; called at a negedge, returns at a later negedge.
    task automatic run_q(input string tag);
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            bus.mem_ready   = c.rdy;
            bus.branch_cond = c.bc;
            #1;
            check({tag, ".state"}, 32'(bus.state), 32'(c.st));
            check({tag, ".outs"}, 32'(obs_o), 32'(c.o));
            if (c.st != 3'd5) exp_cyc++;
            if (c.o[1]) exp_ret++;
            @(negedge clk);
        end
`ifdef MULTICYCLE_CTRL_PERF_EN
        #1;
        check({tag, ".cycle_cnt"}, cycle_cnt, 32'(exp_cyc));
        check({tag, ".retire_cnt"}, retire_cnt, 32'(exp_ret));
`endif
    endtask

    task automatic do_instr(input string tag, input logic [6:0] op, input int fw, input int mw,
                            input logic bc);
        bus.opcode = op;
        build(op, fw, mw, bc);
        run_q(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.branch_cond = 1'b1;
        exp_cyc = 0;
        exp_ret = 0;
        #1;
        check({tag, ".rst_state"}, 32'(bus.state), 32'd0);
        check({tag, ".rst_outs"}, 32'(obs_o), 32'd0);
        @(negedge clk);
        #1;
        check({tag, ".rst_outs_held"}, 32'(obs_o), 32'd0);
`ifdef MULTICYCLE_CTRL_PERF_EN
        check({tag, ".rst_cycle_cnt"}, cycle_cnt, 32'd0);
        check({tag, ".rst_retire_cnt"}, retire_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [6:0] legal_ops [5];

    initial begin
        legal_ops[0] = OP_R; legal_ops[1] = OP_I; legal_ops[2] = OP_LD;
        legal_ops[3] = OP_ST; legal_ops[4] = OP_BR;
        bus.opcode = 7'd0;
        bus.mem_ready = 1'b0;
        bus.branch_cond = 1'b0;
        @(negedge clk);
        do_reset("init");

        do_instr("add", OP_R, 0, 0, 1'b0);
        do_instr("addi", OP_I, 0, 0, 1'b0);
        do_instr("load_wait3", OP_LD, 0, 3, 1'b0);
        do_instr("store", OP_ST, 0, 0, 1'b1);
        do_instr("beq_taken", OP_BR, 0, 0, 1'b1);
        do_instr("beq_not", OP_BR, 0, 0, 1'b0);
        do_instr("fetch_wait15", OP_R, TMO - 1, 0, 1'b0);
        do_instr("store_wait15", OP_ST, 2, TMO - 1, 1'b0);

        for (int n = 0; n < 30; n++)
            do_instr("rand", legal_ops[$urandom_range(0, 4)], $urandom_range(0, 3),
                     $urandom_range(0, 3), 1'($urandom));

        do_instr("fetch_timeout", OP_R, TMO, 0, 1'b0);
        do_reset("after_ftmo");
        do_instr("load_timeout", OP_LD, 1, TMO, 1'b0);
        do_reset("after_mtmo");
        do_instr("illegal", OP_BAD, 0, 0, 1'b0);
        do_reset("after_illegal");
        do_instr("post_illegal", OP_LD, 0, 0, 1'b0);

        // Reset lands in the middle of a store's memory wait.
        do_reset("pre_store");
        bus.opcode = OP_ST;
        build(OP_ST, 0, 5, 1'b0);
        while (q.size() > 5) void'(q.pop_back());
        run_q("store_cut");
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("midstore.state", 32'(bus.state), 32'd0);
        check("midstore.mem_req", 32'(bus.mem_req), 32'd0);
        check("midstore.mem_we", 32'(bus.mem_we), 32'd0);
        check("midstore.retired", 32'(bus.instr_retired), 32'd0);
`ifdef MULTICYCLE_CTRL_PERF_EN
        check("midstore.retire_cnt", retire_cnt, 32'd0);
`endif
        exp_cyc = 0;
        exp_ret = 0;
        @(negedge clk);
        rst = 1'b0;
        do_instr("post_rst_add", OP_R, 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencing controller for the RV32I core.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB over several cycles, sharing one ALU and one memory port.
- Drives the datapath muxes and enables from the opcode and a memory ready handshake.
- Traps on illegal opcodes and on memory timeouts.

Parameters:
- MEM_TIMEOUT, 16, max cycles a memory request (FETCH or MEM) may wait for mem_ready before TRAP; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- opcode  input  7  instr[6:0] from the instruction register; valid from DECODE onward.
- branch_cond  input  1  branch comparison result from the ALU; valid in EXEC.
- mem_ready  input  1  memory completes the request this cycle.
- mem_req  output  1  memory request, held until mem_ready.
- mem_we  output  1  store request; qualified by mem_req.
- iord  output  1  memory address select: 0 = PC, 1 = ALU result.
- ir_write  output  1  load the instruction register.
- pc_write  output  1  load the PC.
- pc_src  output  1  PC source: 0 = PC+4, 1 = branch target register.
- target_write  output  1  latch PC+imm into the branch target register.
- alu_src_a  output  1  ALU operand A: 0 = PC, 1 = rs1.
- alu_src_b  output  2  ALU operand B: 00 = rs2, 01 = imm, 10 = constant 4.
- alu_op  output  2  00 = add, 01 = branch compare, 10 = funct-decoded.
- reg_write  output  1  register file write enable.
- mem_to_reg  output  1  writeback source: 1 = memory data, 0 = ALU result.
- instr_retired  output  1  one-cycle pulse per completed instruction.
- trap  output  1  sticky; set on illegal opcode or memory timeout.
- state  output  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.

Behaviour:
- Reset:
  - Async assert forces state=FETCH and clears the opcode latch and the wait counter.
  - While rst=1 all outputs are 0, including mem_req.
  - First mem_req=1 appears in the cycle after rst deasserts.
- Outputs are combinational from state, the latched opcode class, branch_cond and mem_ready.
- Any output not listed for a state is 0.
- FETCH:
  - mem_req=1, iord=0, alu_src_a=0, alu_src_b=10, alu_op=00.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0; go to DECODE.
  - Otherwise stay and increment the wait counter.
- DECODE:
  - alu_src_a=0, alu_src_b=01, target_write=1.
  - Latch the opcode class: R=0110011, I=0010011, LOAD=0000011, STORE=0100011, BR=1100011.
  - Valid class goes to EXEC; any other opcode goes to TRAP.
- EXEC: alu_src_a=1, then by class:
  - R: alu_src_b=00, alu_op=10; go to WB.
  - I: alu_src_b=01, alu_op=10; go to WB.
  - LOAD/STORE: alu_src_b=01, alu_op=00; go to MEM.
  - BR: alu_src_b=00, alu_op=01, instr_retired=1. If branch_cond: pc_write=1, pc_src=1. Go to FETCH.
- MEM:
  - mem_req=1, iord=1, mem_we = (class==STORE).
  - On mem_ready: LOAD goes to WB; STORE pulses instr_retired and goes to FETCH.
  - Otherwise stay and increment the wait counter.
- WB:
  - reg_write=1, mem_to_reg = (class==LOAD), instr_retired=1; go to FETCH.
- TRAP:
  - trap=1; all enables 0.
  - Absorbing state; only rst exits.
- Wait counter:
  - Cleared on every entry to FETCH or MEM.
  - Width is clog2(MEM_TIMEOUT+1).
  - If MEM_TIMEOUT!=0 and the counter equals MEM_TIMEOUT-1 while mem_ready=0, go to TRAP next cycle.
  - mem_ready in that same cycle wins: no trap.
- mem_req stays asserted, with constant iord and mem_we, until mem_ready.
- mem_ready outside FETCH and MEM is ignored.
- Minimum latencies with zero-wait memory: R/I 4 cycles, LOAD 5, STORE 4, BR 3.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- When defined, adds two outputs:
  - cycle_cnt[31:0]: increments every cycle not in TRAP.
  - retire_cnt[31:0]: increments on instr_retired.
  - Both clear on rst and wrap modulo 2^32.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset then ADD (0110011), mem_ready always 1 -> states 0,1,2,4,0; reg_write=1 only in WB; instr_retired pulses on cycle 4 after reset release.
- LOW (0000011), mem_ready delayed 3 cycles in MEM -> mem_req, iord=1, mem_we=0 held 4 cycles; then WB with mem_to_reg=1; total latency 8 cycles.
- BEQ (1100011) with branch_cond=1, then with branch_cond=0 -> EXEC pc_write=1, pc_src=1 in the first case; pc_write=0 in the second; both return to FETCH after 3 cycles.
- Illegal opcode 1111111 -> TRAP after DECODE; trap=1 held for 20 cycles while mem_ready toggles; rst clears it.
- MEM_TIMEOUT=16, mem_ready=0 in FETCH -> TRAP entered exactly 16 cycles after FETCH entry. Repeat with mem_ready=1 on the 16th cycle -> DECODE, no trap.
- Async rst asserted mid-MEM of a STORE -> mem_req and mem_we drop the same cycle; after release state=FETCH, no instr_retired. With MULTICYCLE_CTRL_PERF_EN, retire_cnt=0.
